bus_ram: RTL and testbench

BUS_RAM -- requirements
Module: bus_ram

---
 rtl/bus_ram.sv | 172 +++++++++++++++++
 tb/tb_bus_ram.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_ram.sv
`default_nettype none
// ============================================================================
//  Module   : bus_ram
//  Purpose  : Word-addressed RAM attached to a shared, multiplexed
//             address/data bus. A transfer is one or more address beats
//             (least significant first), then data beats. Reads insert one
//             turnaround cycle before the RAM drives the bus.
//  Revision : 1.0  initial release
//
//  Ports
//    clock    in     rising-edge system clock
//    n_reset  in     asynchronous active-low reset
//    enable   in     transfer-valid strobe from the bus master
//    rw       in     direction, 1 = write, 0 = read (first address beat only)
//    bus      inout  multiplexed address/data bus, DATA_WIDTH bits
//    busy     out    high whenever a transfer is in progress
//    drive    out    high exactly when this block drives bus
//
//  Configuration macro
//    BUS_RAM_BURST_EN  defined   : data beats continue with an incrementing
//                                  address (wrapping DEPTH-1 -> 0) until
//                                  enable drops.
//                      undefined : exactly one data beat per transfer.
// ============================================================================
module bus_ram #(
    parameter int              DATA_WIDTH = 8,
    parameter int              ADDR_WIDTH = 8,
    parameter longint unsigned DEPTH      = 64'd1 << ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  n_reset,
    input  logic                  enable,
    input  logic                  rw,
    inout  wire  [DATA_WIDTH-1:0] bus,
    output logic                  busy,
    output logic                  drive
);

    localparam int ADDR_BEATS = (ADDR_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int BEAT_W     = (ADDR_BEATS > 1) ? $clog2(ADDR_BEATS) : 1;

    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(ADDR_BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 64'd1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = DEPTH[ADDR_WIDTH:0];

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_TURN  = 3'd2,
        S_WDATA = 3'd3,
        S_RDATA = 3'd4
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    rw_q;
    logic [BEAT_W-1:0]       beat_q;
    logic                    done_q;   // at least one data beat completed
    logic                    busy_q;
    logic                    drive_q;

    logic [DATA_WIDTH-1:0]   mem_q [0:DEPTH-1];
    logic                    in_range;
    logic [DATA_WIDTH-1:0]   rd_data;

    assign in_range = ({1'b0, addr_q} < DEPTH_W);
    assign rd_data  = in_range ? mem_q[addr_q] : '0;

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    if (ADDR_BEATS > 1)
                        state_d = S_ADDR;
                    else
                        state_d = rw ? S_WDATA : S_TURN;
                end
            end
            S_ADDR: begin
                if (enable && (beat_q == LAST_BEAT))
                    state_d = rw_q ? S_WDATA : S_TURN;
            end
            S_TURN: begin
                state_d = S_RDATA;
            end
            S_WDATA, S_RDATA: begin
                if (enable) begin
`ifdef BUS_RAM_BURST_EN
                    state_d = state_q;
`else
                    state_d = S_IDLE;
`endif
                end else if (done_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers. busy/drive are registered from the next state so
    // they change together with the state and are glitch-free.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            beat_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            drive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
            drive_q <= (state_d == S_RDATA);
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        rw_q   <= rw;
                        beat_q <= BEAT_W'(1);
                        done_q <= 1'b0;
                        // Beat 0 fills the low DATA_WIDTH bits, rest cleared.
                        for (int b = 0; b < ADDR_WIDTH; b++)
                            addr_q[b] <= (b / DATA_WIDTH == 0) ? bus[b % DATA_WIDTH] : 1'b0;
                    end
                end
                S_ADDR: begin
                    if (enable) begin
                        for (int b = 0; b < ADDR_WIDTH; b++)
                            if (b / DATA_WIDTH == int'(beat_q))
                                addr_q[b] <= bus[b % DATA_WIDTH];
                        beat_q <= beat_q + 1'b1;
                    end
                end
                S_TURN: begin
                    done_q <= 1'b0;
                end
                S_WDATA, S_RDATA: begin
                    if (enable) begin
                        done_q <= 1'b1;
`ifdef BUS_RAM_BURST_EN
                        addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage: not reset. A reset asserted across an edge forces state_q
    // to IDLE first, so no write can slip through during reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if ((state_q == S_WDATA) && enable && in_range)
            mem_q[addr_q] <= bus;
    end

    assign bus   = drive_q ? rd_data : {DATA_WIDTH{1'bz}};
    assign busy  = busy_q;
    assign drive = drive_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_ram.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_ram
//  Purpose  : Self-checking bench for bus_ram. Three instances share clock
//             and reset: 8-bit address / 256 words, 12-bit address / 4096
//             words (two address beats), 8-bit address / 200 words (range
//             checks). A simple array holds the expected memory contents.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bus_ram;

`ifdef BUS_RAM_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       n_rst;
    logic       en_r  [3];
    logic       rw_r  [3];
    logic       dr_r  [3];
    logic [7:0] val_r [3];
    wire  [7:0] bus0, bus1, bus2;
    wire        busy0, busy1, busy2;
    wire        drive0, drive1, drive2;

    assign bus0 = dr_r[0] ? val_r[0] : 8'bz;
    assign bus1 = dr_r[1] ? val_r[1] : 8'bz;
    assign bus2 = dr_r[2] ? val_r[2] : 8'bz;

    bus_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) u_dut0 (
        .clock(clk), .n_reset(n_rst), .enable(en_r[0]), .rw(rw_r[0]),
        .bus(bus0), .busy(busy0), .drive(drive0));

    bus_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .DEPTH(4096)) u_dut1 (
        .clock(clk), .n_reset(n_rst), .enable(en_r[1]), .rw(rw_r[1]),
        .bus(bus1), .busy(busy1), .drive(drive1));

    bus_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(200)) u_dut2 (
        .clock(clk), .n_reset(n_rst), .enable(en_r[2]), .rw(rw_r[2]),
        .bus(bus2), .busy(busy2), .drive(drive2));

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] model [256];
    logic [7:0] wr_q [$];
    logic [7:0] rd_q [$];

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;   // write data, or expected read value
    } vec_t;

    vec_t vecs [11];

    function automatic logic get_busy(input int s);
        case (s)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic get_drive(input int s);
        case (s)
            0:       return drive0;
            1:       return drive1;
            default: return drive2;
        endcase
    endfunction

    function automatic logic [7:0] get_bus(input int s);
        case (s)
            0:       return bus0;
            1:       return bus1;
            default: return bus2;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int s, input bit e, input bit r, input logic [7:0] v, input bit d);
        en_r[s]  = e;
        rw_r[s]  = r;
        val_r[s] = v;
        dr_r[s]  = d;
    endtask

    task automatic send_addr(input int s, input bit r, input logic [15:0] a, input int nb);
        for (int i = 0; i < nb; i++) begin
            // rw only matters on the first beat; later beats get noise
            set_in(s, 1'b1, (i == 0) ? r : 1'($urandom_range(0, 1)), a[8*i +: 8], 1'b1);
            tick();
        end
    endtask

    task automatic do_write(input int s, input logic [15:0] a, input int nb);
        send_addr(s, 1'b1, a, nb);
        chk("wr_busy_mid", 16'(get_busy(s)), 16'd1);
        foreach (wr_q[k]) begin
            set_in(s, 1'b1, 1'($urandom_range(0, 1)), wr_q[k], 1'b1);
            tick();
        end
        if (BURST) begin
            set_in(s, 1'b0, 1'b0, 8'h00, 1'b0);
            tick();
        end
        set_in(s, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("wr_busy_end", 16'(get_busy(s)), 16'd0);
    endtask

    task automatic do_read(input int s, input logic [15:0] a, input int nb, input int len);
        rd_q.delete();
        send_addr(s, 1'b0, a, nb);
        set_in(s, 1'b0, 1'($urandom_range(0, 1)), 8'h00, 1'b0);
        chk("rd_turn_drive", 16'(get_drive(s)), 16'd0);
        chk("rd_turn_busy", 16'(get_busy(s)), 16'd1);
        tick();
        for (int k = 0; k < len; k++) begin
            chk("rd_drive", 16'(get_drive(s)), 16'd1);
            rd_q.push_back(get_bus(s));
            set_in(s, 1'b1, 1'b0, 8'h00, 1'b0);
            tick();
        end
        if (BURST) begin
            set_in(s, 1'b0, 1'b0, 8'h00, 1'b0);
            tick();
        end
        set_in(s, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("rd_busy_end", 16'(get_busy(s)), 16'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         a;
        int         len;
        logic [7:0] d;
        logic [7:0] pre;

        vecs[0]  = '{1'b1, 8'd10,  8'd15};
        vecs[1]  = '{1'b0, 8'd10,  8'd15};
        vecs[2]  = '{1'b1, 8'd3,   8'hA5};
        vecs[3]  = '{1'b0, 8'd3,   8'hA5};
        vecs[4]  = '{1'b1, 8'd0,   8'h00};
        vecs[5]  = '{1'b1, 8'hFF,  8'hFF};
        vecs[6]  = '{1'b0, 8'hFF,  8'hFF};
        vecs[7]  = '{1'b0, 8'd0,   8'h00};
        vecs[8]  = '{1'b1, 8'd3,   8'h5A};
        vecs[9]  = '{1'b0, 8'd3,   8'h5A};
        vecs[10] = '{1'b0, 8'd10,  8'd15};

        for (int s = 0; s < 3; s++) set_in(s, 1'b0, 1'b0, 8'h00, 1'b0);
        n_rst = 1'b0;
        #3;
        chk("rst_busy0", 16'(busy0), 16'd0);
        chk("rst_drive0", 16'(drive0), 16'd0);
        chk("rst_busy1", 16'(busy1), 16'd0);
        #9 n_rst = 1'b1;   // released between edges
        tick();

        // Fill the whole 256-word memory so every later read is predictable.
        for (int i = 0; i < 256; i++) begin
            d = 8'($urandom);
            model[i] = d;
            wr_q = {d};
            do_write(0, 16'(i), 1);
        end

        // Directed vector table.
        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                wr_q = {vecs[i].data};
                model[vecs[i].addr] = vecs[i].data;
                do_write(0, 16'(vecs[i].addr), 1);
            end else begin
                do_read(0, 16'(vecs[i].addr), 1, 1);
                chk("vec_rd", 16'(rd_q[0]), 16'(vecs[i].data));
            end
        end

        if (BURST) begin
            // Burst write wrapping from the top of memory to address 0.
            wr_q = {8'd1, 8'd2, 8'd3};
            model[254] = 8'd1; model[255] = 8'd2; model[0] = 8'd3;
            do_write(0, 16'd254, 1);
            do_read(0, 16'd254, 1, 1);
            chk("burst_254", 16'(rd_q[0]), 16'd1);
            do_read(0, 16'd255, 1, 1);
            chk("burst_255", 16'(rd_q[0]), 16'd2);
            do_read(0, 16'd0, 1, 1);
            chk("burst_0", 16'(rd_q[0]), 16'd3);
            do_read(0, 16'd254, 1, 3);
            chk("burst_rd0", 16'(rd_q[0]), 16'd1);
            chk("burst_rd1", 16'(rd_q[1]), 16'd2);
            chk("burst_rd2", 16'(rd_q[2]), 16'd3);
        end else begin
            // Single-beat write: the second data value is taken as a new
            // address (8), which is then completed with its current contents.
            pre = model[21];
            send_addr(0, 1'b1, 16'd20, 1);
            set_in(0, 1'b1, 1'b1, 8'd7, 1'b1);
            tick();
            chk("nb_busy_after_beat", 16'(busy0), 16'd0);
            set_in(0, 1'b1, 1'b1, 8'd8, 1'b1);
            tick();
            chk("nb_new_xfer_busy", 16'(busy0), 16'd1);
            set_in(0, 1'b1, 1'b0, model[8], 1'b1);
            tick();
            set_in(0, 1'b0, 1'b0, 8'h00, 1'b0);
            model[20] = 8'd7;
            do_read(0, 16'd20, 1, 1);
            chk("nb_mem20", 16'(rd_q[0]), 16'd7);
            do_read(0, 16'd21, 1, 1);
            chk("nb_mem21", 16'(rd_q[0]), 16'(pre));
            do_read(0, 16'd8, 1, 1);
            chk("nb_mem8", 16'(rd_q[0]), 16'(model[8]));
        end

        // Reset during RDATA: outputs drop without a clock edge.
        send_addr(0, 1'b0, 16'd3, 1);
        set_in(0, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        chk("mid_rd_drive_before", 16'(drive0), 16'd1);
        #2 n_rst = 1'b0;
        #1;
        chk("mid_rd_rst_busy", 16'(busy0), 16'd0);
        chk("mid_rd_rst_drive", 16'(drive0), 16'd0);
        @(negedge clk) n_rst = 1'b1;
        tick();
        do_read(0, 16'd3, 1, 1);
        chk("mid_rd_mem3", 16'(rd_q[0]), 16'(model[3]));

        // Reset held across an edge while a write beat is presented.
        send_addr(0, 1'b1, 16'd40, 1);
        set_in(0, 1'b1, 1'b1, 8'(model[40] ^ 8'hFF), 1'b1);
        #2 n_rst = 1'b0;
        @(posedge clk);
        set_in(0, 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk) n_rst = 1'b1;
        tick();
        do_read(0, 16'd40, 1, 1);
        chk("mid_wr_mem40", 16'(rd_q[0]), 16'(model[40]));

        // Two-beat address instance.
        wr_q = {8'h11};
        do_write(1, 16'h034, 2);
        wr_q = {8'h5A};
        do_write(1, 16'h234, 2);
        wr_q = {8'hC3};
        do_write(1, 16'hFFF, 2);
        do_read(1, 16'h234, 2, 1);
        chk("mb_234", 16'(rd_q[0]), 16'h5A);
        do_read(1, 16'h034, 2, 1);
        chk("mb_034", 16'(rd_q[0]), 16'h11);
        do_read(1, 16'hFFF, 2, 1);
        chk("mb_fff", 16'(rd_q[0]), 16'hC3);

        // Out-of-range handling on the 200-word instance.
        wr_q = {8'h77};
        do_write(2, 16'd199, 1);
        wr_q = {8'h99};
        do_write(2, 16'd200, 1);
        do_read(2, 16'd199, 1, 1);
        chk("oor_last_valid", 16'(rd_q[0]), 16'h77);
        do_read(2, 16'd200, 1, 1);
        chk("oor_200", 16'(rd_q[0]), 16'h00);
        do_read(2, 16'd250, 1, 1);
        chk("oor_250", 16'(rd_q[0]), 16'h00);

        // Randomised traffic against the array model.
        for (int i = 0; i < 150; i++) begin
            a   = $urandom_range(0, 255);
            len = BURST ? $urandom_range(1, 4) : 1;
            if ($urandom_range(0, 1) == 1) begin
                wr_q.delete();
                for (int k = 0; k < len; k++) begin
                    d = 8'($urandom);
                    wr_q.push_back(d);
                    model[(a + k) % 256] = d;
                end
                do_write(0, 16'(a), 1);
            end else begin
                do_read(0, 16'(a), 1, len);
                for (int k = 0; k < len; k++)
                    chk("rand_rd", 16'(rd_q[k]), 16'(model[(a + k) % 256]));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
